// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage: the memory-to-writeback
// pipeline record, the writeback source select codes, the load funct3 codes
// and small sign-extension helpers.
package wb_stage_pkg;

    // Writeback value source; code 3 is reserved and behaves like WB_ALU.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // Load width/extension codes carried in funct3.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Memory-stage result record, mapped one-to-one onto the WB register.
    typedef struct packed {
        logic        valid;
        logic [31:0] opr_res;
        logic [31:0] dmem_rdata;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        wb_en;
        logic [1:0]  wb_sel;
        logic [2:0]  ld_funct3;
    } wb_stage_in_t;

    // Sign-extend a byte to a 32-bit word.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Sign-extend a halfword to a 32-bit word.
    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bus bundle between the memory stage / hazard control and the writeback
// stage: incoming record, stall/flush controls, register-file write port and
// the retired-instruction count.
interface wb_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
) ();
    import wb_stage_pkg::*;

    logic                  stall;
    logic                  flush;
    wb_stage_in_t          wb_stage_in;
    logic                  rf_wen;
    logic [4:0]            rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [CNT_WIDTH-1:0]  instret;

    // Writeback stage side.
    modport slave (
        input  stall,
        input  flush,
        input  wb_stage_in,
        output rf_wen,
        output rf_waddr,
        output rf_wdata,
        output instret
    );

    // Pipeline / hazard-control side.
    modport master (
        output stall,
        output flush,
        output wb_stage_in,
        input  rf_wen,
        input  rf_waddr,
        input  rf_wdata,
        input  instret
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword lane of a
// little-endian 32-bit read word and sign- or zero-extends it per funct3.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte lane and halfword lane (halfword ignores offset[0]).
    always_comb begin
        byte_s = rdata[7:0];
        half_s = rdata[15:0];
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane; unknown codes and LW pass the full word.
    always_comb begin
        data = rdata;
        case (funct3)
            LB:      data = sext8(byte_s);
            LBU:     data = {24'h00_0000, byte_s};
            LH:      data = sext16(half_s);
            LHU:     data = {16'h0000, half_s};
            LW:      data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load alignment, writeback value
// select, register-file write port and the retired-instruction counter.
// The write port is combinational from the register so the same value serves
// as the forwarding source.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
) (
    input  logic         clk,
    input  logic         arst,
    wb_stage_if.slave    bus
);

    wb_stage_in_t          stage_d;
    wb_stage_in_t          stage_q;
    logic [CNT_WIDTH-1:0]  instret_d;
    logic [CNT_WIDTH-1:0]  instret_q;
    logic                  commit_s;
    logic [31:0]           load_data_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    load_align u_load_align (
        .rdata  (stage_q.dmem_rdata),
        .offset (stage_q.opr_res[1:0]),
        .funct3 (stage_q.ld_funct3),
        .data   (load_data_s)
    );

    // Next register contents: flush inserts a bubble (fields kept), stall holds, otherwise load.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d.valid = 1'b0;
        end else if (bus.stall) begin
            stage_d = stage_q;
        end else begin
            stage_d = bus.wb_stage_in;
        end
    end

    // Commit decision and retired-instruction count; every commit retires, write or not.
    always_comb begin
        commit_s  = stage_q.valid & ~bus.stall & ~bus.flush;
        instret_d = instret_q;
        if (commit_s) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // Writeback value select; the reserved code falls back to the ALU result.
    always_comb begin
        wdata_s = stage_q.opr_res;
        case (wb_sel_e'(stage_q.wb_sel))
            WB_ALU:  wdata_s = stage_q.opr_res;
            WB_MEM:  wdata_s = load_data_s;
            WB_PC4:  wdata_s = stage_q.pc_plus4;
            default: wdata_s = stage_q.opr_res;
        endcase
    end

    // Pipeline register and counter; reset drops any held instruction.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stage_q   <= '0;
            instret_q <= '0;
        end else begin
            stage_q   <= stage_d;
            instret_q <= instret_d;
        end
    end

    // Register-file port: x0 writes suppressed, address always driven.
    assign bus.rf_wen   = commit_s & stage_q.wb_en & (stage_q.rd != 5'd0);
    assign bus.rf_waddr = stage_q.rd;
    assign bus.rf_wdata = wdata_s;
    assign bus.instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected register-file
// writes into a queue from a behavioural model; a negedge monitor pops and
// compares writes and checks address, data and the retired count each cycle.
module tb_wb_stage;
    import wb_stage_pkg::*;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic arst;
    int   checks;
    int   errors;
    int   cyc;

    wr_t          q[$];
    wb_stage_in_t held;
    logic [63:0]  exp_instret;

    wb_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(64)) bus ();

    wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(64)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference writeback value computed from the lane/extension rules.
    function automatic logic [31:0] model_wdata(input wb_stage_in_t h);
        logic [31:0] bsh;
        logic [31:0] hsh;
        logic [7:0]  b;
        logic [15:0] hw;
        logic [31:0] r;
        bsh = h.dmem_rdata >> {h.opr_res[1:0], 3'b000};
        hsh = h.dmem_rdata >> {h.opr_res[1], 4'b0000};
        b   = bsh[7:0];
        hw  = hsh[15:0];
        r   = h.opr_res;
        if (h.wb_sel == 2'd2) begin
            r = h.pc_plus4;
        end else if (h.wb_sel == 2'd1) begin
            case (h.ld_funct3)
                3'b000:  r = {{24{b[7]}}, b};
                3'b100:  r = {24'd0, b};
                3'b001:  r = {{16{hw[15]}}, hw};
                3'b101:  r = {16'd0, hw};
                default: r = h.dmem_rdata;
            endcase
        end
        return r;
    endfunction

    function automatic wb_stage_in_t mk(input logic v, input logic [31:0] opr,
                                        input logic [31:0] dm, input logic [31:0] pc,
                                        input logic [4:0] rd, input logic we,
                                        input logic [1:0] sel, input logic [2:0] f3);
        wb_stage_in_t s;
        s.valid = v; s.opr_res = opr; s.dmem_rdata = dm; s.pc_plus4 = pc;
        s.rd = rd; s.wb_en = we; s.wb_sel = sel; s.ld_funct3 = f3;
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive at posedge+1, predict commit, advance the model after the edge.
    task automatic step(input wb_stage_in_t in, input logic st, input logic fl);
        logic commit;
        wr_t  e;
        bus.wb_stage_in = in;
        bus.stall       = st;
        bus.flush       = fl;
        commit = held.valid && !st && !fl;
        if (commit && held.wb_en && held.rd != 5'd0) begin
            e.cyc = cyc; e.addr = held.rd; e.data = model_wdata(held);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (commit) exp_instret = exp_instret + 64'd1;
        if (fl) held.valid = 1'b0;
        else if (!st) held = in;
        cyc = cyc + 1;
    endtask

    // Monitor: compare DUT outputs against the model away from the active edge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            chk("instret", bus.instret, exp_instret);
            chk("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, held.rd});
            chk("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, model_wdata(held)});
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("stale_write", 64'(e.cyc), 64'(cyc));
            end
            if (bus.rf_wen) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("write_addr", {59'd0, bus.rf_waddr}, {59'd0, e.addr});
                    chk("write_data", {32'd0, bus.rf_wdata}, {32'd0, e.data});
                end
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("missing_write", 64'd0, 64'd1);
            end
        end
    end

    typedef struct {
        logic [1:0]  off;
        logic [2:0]  f3;
        logic [31:0] exp;
    } ld_t;

    initial begin
        ld_t          lds[6];
        wb_stage_in_t idle;
        wb_stage_in_t r;
        checks = 0; errors = 0; cyc = 0;
        held = '0; exp_instret = 64'd0;
        idle = '0;
        arst = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.wb_stage_in = '0;
        #1;
        chk("reset_instret", bus.instret, 64'd0);
        chk("reset_rf_wen", {63'd0, bus.rf_wen}, 64'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        cyc = cyc + 1;

        // ALU writeback
        step(mk(1'b1, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 2'd0, LW), 1'b0, 1'b0);
        chk("alu_wen", {63'd0, bus.rf_wen}, 64'd1);
        chk("alu_waddr", {59'd0, bus.rf_waddr}, 64'd5);
        chk("alu_wdata", {32'd0, bus.rf_wdata}, 64'h1234);

        // Load extension cases on 0x80FF_7F01
        lds[0] = '{2'd3, LB,  32'hFFFF_FF80};
        lds[1] = '{2'd2, LBU, 32'h0000_00FF};
        lds[2] = '{2'd0, LH,  32'h0000_7F01};
        lds[3] = '{2'd2, LH,  32'hFFFF_80FF};
        lds[4] = '{2'd3, LHU, 32'h0000_80FF};
        lds[5] = '{2'd1, LW,  32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            step(mk(1'b1, {30'h100, lds[i].off}, 32'h80FF_7F01, 32'h0, 5'(i + 10), 1'b1, 2'd1,
                    lds[i].f3), 1'b0, 1'b0);
            chk($sformatf("load_%0d", i), {32'd0, bus.rf_wdata}, {32'd0, lds[i].exp});
        end

        // x0 suppressed but counted; PC+4 writeback
        step(mk(1'b1, 32'h55, 32'h0, 32'h0, 5'd0, 1'b1, 2'd0, LW), 1'b0, 1'b0);
        chk("x0_wen", {63'd0, bus.rf_wen}, 64'd0);
        step(mk(1'b1, 32'h55, 32'h0, 32'h104, 5'd1, 1'b1, 2'd2, LW), 1'b0, 1'b0);
        chk("pc4_wdata", {32'd0, bus.rf_wdata}, 64'h104);

        // Stall three cycles, then release; then stall and flush together
        step(mk(1'b1, 32'h777, 32'h0, 32'h0, 5'd7, 1'b1, 2'd0, LW), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(idle, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b0);
        step(mk(1'b1, 32'h999, 32'h0, 32'h0, 5'd9, 1'b1, 2'd0, LW), 1'b0, 1'b0);
        step(idle, 1'b1, 1'b1);
        step(idle, 1'b0, 1'b0);

        // Asynchronous reset with a valid instruction held
        step(mk(1'b1, 32'hABCD, 32'h0, 32'h0, 5'd3, 1'b1, 2'd0, LW), 1'b0, 1'b0);
        held = '0; exp_instret = 64'd0;
        arst = 1'b1;
        #1;
        chk("arst_wen", {63'd0, bus.rf_wen}, 64'd0);
        chk("arst_wdata", {32'd0, bus.rf_wdata}, 64'd0);
        chk("arst_instret", bus.instret, 64'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        cyc = cyc + 1;
        step(mk(1'b1, 32'h4444, 32'h0, 32'h0, 5'd4, 1'b1, 2'd0, LW), 1'b0, 1'b0);
        step(idle, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = mk(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)));
            step(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Counter wrap: preload all-ones, then retire one instruction
        force dut.instret_d = {64{1'b1}};
        step(idle, 1'b0, 1'b0);
        release dut.instret_d;
        exp_instret = {64{1'b1}};
        chk("preload_instret", bus.instret, {64{1'b1}});
        step(mk(1'b1, 32'h1, 32'h0, 32'h0, 5'd2, 1'b1, 2'd0, LW), 1'b0, 1'b0);
        step(idle, 1'b0, 1'b0);
        chk("wrap_instret", bus.instret, 64'd0);

        step(idle, 1'b0, 1'b0);
        step(idle, 1'b0, 1'b0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
